mips_core: RTL and testbench
============================

// Module: mips_core
// PURPOSE
// - Single-cycle 32-bit MIPS integer core with internal instruction memory, data memory and register file.
// - One instruction is fetched, executed and retired every clk rising edge.
// - Top-level processor block. Benches preload memories and registers hierarchically, then run on clk.
// PARAMETERS
// - IMEM_DEPTH  256           instruction memory depth, 32-bit words
// - DMEM_DEPTH  256           data memory depth, 32-bit words
// - RESET_PC    32'h00000000  PC value loaded at reset
// PORTS
// - clk     in   1   single system clock, rising-edge active
// - rst_n   in   1   asynchronous active-low reset
// - dbg_pc  out  32  current PC (equals register PC)
// BEHAVIOUR
// - State: PC[31:0], instMem[0:IMEM_DEPTH-1], dataMem[0:DMEM_DEPTH-1], 32x32 register file (instance mipsRegFile, array registers).
// - rst_n low (async): PC=RESET_PC; all 32 registers=0; dbg_pc=RESET_PC; memories not reset.
// - Fetch: inst = instMem[PC[31:2] mod IMEM_DEPTH], combinational. PC[1:0] ignored; addresses wrap.
// - Register reads combinational. Register write, dataMem write and PC update at posedge clk.
// - $0 always reads 0; writes to $0 discarded.
// - R-type (op=0), decoded by funct:
//   - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed), 0x00 sll by shamt.
//   - Result goes to rd.
// - I-type: 0x08 addi / 0x09 addiu (sign-ext imm); 0x0C andi / 0x0D ori (zero-ext imm); 0x0F lui (imm<<16). Result goes to rt.
// - 0x23 lw: rt = dataMem[(rs+sext(imm))[31:2] mod DMEM_DEPTH], read combinational, written at the edge.
// - 0x2B sw: dataMem[same address] = rt at the edge.
// - 0x04 beq / 0x05 bne: if taken, PC = PC+4+(sext(imm)<<2); else PC = PC+4.
// - Arithmetic: 32-bit two's complement, wraps. Overflow never traps (add == addu). No delay slots. No exceptions.
// - Unknown opcode or funct: NOP. No register or memory write; PC = PC+4. Word 0x00000000 (sll $0) is therefore a NOP.
// - Read-during-write: a source register that is also the destination reads the old value. Result is visible next cycle.
// - Reset asserted mid-run overrides any pending write on that edge.
// CONFIGURATION
// - MIPS_JUMP_EN defined: 0x02 j → PC = {PC+4[31:28], target, 2'b00}; 0x03 jal also writes $31 = PC+4.
// - MIPS_JUMP_EN undefined: opcodes 0x02/0x03 are NOPs (PC+4, no writes).
// STRUCTURE
// - Package mips_pkg: opcode constants, funct constants, ALU-op enum (ADD, SUB, AND, OR, NOR, SLT, SLL, LUI), control-signal struct.
// - Sub-module mips_reg_file: 2 async read ports, 1 sync write port, async active-low clear. Instance name mipsRegFile, storage array registers.
// - Decoder and ALU stay inline in mips_core.
// TESTING
// - add: r1=1, r2=0, instMem[0]=0x00411020 (add $2,$2,$1), rest 0 → after edge 1: r2=1, PC=4; after edge 5: r2=1, PC=20.
// - addi/sw/lw: addi $3,$0,-5; sw $3,8($0); lw $4,8($0) → dataMem[2]=0xFFFFFFFB, r4=0xFFFFFFFB, PC=12.
// - beq: r5=r6=7, instMem[0]=beq $5,$6,+2 → PC=12 next edge; with r6=8 → PC=4.
// - $0 guard: addi $0,$0,9 → r0 stays 0. slt $7,$8,$9 with r8=-1, r9=1 → r7=1.
// - Async reset: pulse rst_n low between edges mid-program → PC=0, all regs 0 immediately, without waiting for a clk edge.
// - j 0x10 (instMem[0]=0x08000010) → PC=0x40 with MIPS_JUMP_EN defined; PC=4 without it.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU operation enum and decoded control bundle for mips_core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_RD, DST_RT, DST_RA
    } dst_sel_e;

    typedef struct packed {
        logic     reg_write;
        dst_sel_e dst_sel;
        logic     alu_src_imm;
        logic     imm_zext;
        alu_op_e  alu_op;
        logic     mem_to_reg;
        logic     mem_write;
        logic     branch_eq;
        logic     branch_ne;
        logic     jump;
        logic     link;
    } ctrl_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_reg_file.sv
// 32x32 register file: two combinational read ports, one write port, async active-low clear; $0 is hard zero.
module mips_reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] registers [0:31];

    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : registers[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : registers[rt_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            registers[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS integer core with internal instruction/data memories.
// Optional j/jal support is enabled by defining MIPS_JUMP_EN.
module mips_core
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] dbg_pc
);

    localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [31:0] instMem [0:IMEM_DEPTH-1];
    logic [31:0] dataMem [0:DMEM_DEPTH-1];

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] inst;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_ext;
    ctrl_t       ctrl;

    logic [31:0] rs_data, rt_data, alu_b, alu_result, wr_data, dmem_rdata;
    logic [4:0]  wr_addr;
    logic [IA_W-1:0] imem_idx;
    logic [DA_W-1:0] dmem_idx;

    // Word addressing; low address bits are ignored and indices wrap at the memory depth.
    assign imem_idx = IA_W'(pc_q[31:2] % 30'(IMEM_DEPTH));
    assign inst     = instMem[imem_idx];

    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign shamt    = inst[10:6];
    assign funct    = inst[5:0];
    assign imm      = inst[15:0];
    assign imm_sext = sign_ext16(imm);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RD;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:          ctrl.alu_op = ALU_AND;
                    FN_OR:           ctrl.alu_op = ALU_OR;
                    FN_NOR:          ctrl.alu_op = ALU_NOR;
                    FN_SLT:          ctrl.alu_op = ALU_SLT;
                    FN_SLL:          ctrl.alu_op = ALU_SLL;
                    default:         ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.reg_write   = 1'b1;
                ctrl.dst_sel     = DST_RT;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_ADD;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.dst_sel     = DST_RT;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zext    = 1'b1;
                ctrl.alu_op      = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
                ctrl.alu_op    = ALU_LUI;
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.dst_sel     = DST_RT;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_ADD;
                ctrl.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_ADD;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ: ctrl.branch_eq = 1'b1;
            OP_BNE: ctrl.branch_ne = 1'b1;
`ifdef MIPS_JUMP_EN
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.link      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RA;
            end
`endif
            default: ;
        endcase
    end

    assign imm_ext = ctrl.imm_zext ? {16'd0, imm} : imm_sext;
    assign alu_b   = ctrl.alu_src_imm ? imm_ext : rt_data;

    always_comb begin
        alu_result = 32'd0;
        case (ctrl.alu_op)
            ALU_ADD: alu_result = rs_data + alu_b;
            ALU_SUB: alu_result = rs_data - alu_b;
            ALU_AND: alu_result = rs_data & alu_b;
            ALU_OR:  alu_result = rs_data | alu_b;
            ALU_NOR: alu_result = ~(rs_data | alu_b);
            ALU_SLT: alu_result = {31'd0, ($signed(rs_data) < $signed(alu_b))};
            ALU_SLL: alu_result = alu_b << shamt;
            ALU_LUI: alu_result = {imm, 16'd0};
            default: alu_result = 32'd0;
        endcase
    end

    assign dmem_idx   = DA_W'(alu_result[31:2] % 30'(DMEM_DEPTH));
    assign dmem_rdata = dataMem[dmem_idx];

    always_comb begin
        wr_addr = rd;
        case (ctrl.dst_sel)
            DST_RT:  wr_addr = rt;
            DST_RA:  wr_addr = 5'd31;
            default: wr_addr = rd;
        endcase
    end

    assign wr_data = ctrl.link       ? pc_plus4   :
                     ctrl.mem_to_reg ? dmem_rdata : alu_result;

    always_comb begin
        pc_d = pc_plus4;
        if ((ctrl.branch_eq && (rs_data == rt_data)) ||
            (ctrl.branch_ne && (rs_data != rt_data))) begin
            pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
        end
`ifdef MIPS_JUMP_EN
        if (ctrl.jump) begin
            pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A store on an edge where reset is held is dropped, matching the register file clear.
    always_ff @(posedge clk) begin
        if (ctrl.mem_write && rst_n) begin
            dataMem[dmem_idx] <= rt_data;
        end
    end

    mips_reg_file mipsRegFile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (ctrl.reg_write),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign dbg_pc = pc_q;

endmodule

// File: tb/tb_mips_core.sv
// Scoreboard bench for mips_core: an ISA-level model predicts PC, one register and one data word per retired instruction.
module tb_mips_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] dbg_pc;

    mips_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dbg_pc (dbg_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          ridx;
        logic [31:0] rval;
        int          midx;
        logic [31:0] mval;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_imem [0:255];
    logic [31:0] m_dmem [0:255];
    logic [31:0] m_pc;
    int          last_r, last_m;

    logic [5:0] fn_tab [0:9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h26};
    logic [5:0] op_tab [0:11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic void m_wr(input int idx, input logic [31:0] val);
        if (idx != 0) m_regs[idx] = val;
        last_r = idx;
    endfunction

    // Architectural reference: one instruction per call, straight from the ISA rules.
    function automatic void model_step();
        logic [31:0] ins, a, b, se, ze, npc, ea;
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh;
        ins = m_imem[m_pc[9:2]];
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
        a = m_regs[rs]; b = m_regs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'd0, ins[15:0]};
        ea = a + se;
        npc = m_pc + 4;
        last_r = $urandom_range(0, 31);
        last_m = $urandom_range(0, 255);
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: m_wr(rd, a + b);
                6'h22, 6'h23: m_wr(rd, a - b);
                6'h24: m_wr(rd, a & b);
                6'h25: m_wr(rd, a | b);
                6'h27: m_wr(rd, ~(a | b));
                6'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h00: m_wr(rd, b << sh);
                default: ;
            endcase
            6'h08, 6'h09: m_wr(rt, a + se);
            6'h0C: m_wr(rt, a & ze);
            6'h0D: m_wr(rt, a | ze);
            6'h0F: m_wr(rt, {ins[15:0], 16'd0});
            6'h23: m_wr(rt, m_dmem[ea[9:2]]);
            6'h2B: begin m_dmem[ea[9:2]] = b; last_m = int'(ea[9:2]); end
            6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
            6'h05: if (a != b) npc = m_pc + 4 + (se << 2);
`ifdef MIPS_JUMP_EN
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin m_wr(31, m_pc + 4); npc = {npc[31:28], ins[25:0], 2'b00}; end
`endif
            default: ;
        endcase
        m_pc = npc;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31) < 24 ? $urandom_range(0, 7) : $urandom_range(0, 31));
        if ($urandom_range(0, 2) == 0) begin
            w = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fn_tab[$urandom_range(0, 9)]};
        end else begin
            op = op_tab[$urandom_range(0, 11)];
            w = {op, rs, rt, 16'($urandom)};
            if (op == 6'h04 || op == 6'h05) w[15:0] = 16'($urandom_range(0, 8) - 4);
            if (op == 6'h02 || op == 6'h03) w[25:0] = 26'($urandom_range(0, 63));
        end
        return w;
    endfunction

    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = 32'd0;
            dut.instMem[i] = 32'd0;
            m_dmem[i] = $urandom;
            dut.dataMem[i] = m_dmem[i];
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        m_imem[idx] = w;
        dut.instMem[idx] = w;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        m_regs[idx] = v;
        dut.mipsRegFile.registers[idx] = v;
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            model_step();
            e.pc = m_pc; e.ridx = last_r; e.rval = m_regs[last_r];
            e.midx = last_m; e.mval = m_dmem[last_m];
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            n_checks++;
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", dbg_pc, e.pc);
                check($sformatf("reg%0d", e.ridx), dut.mipsRegFile.registers[e.ridx], e.rval);
                check($sformatf("dmem%0d", e.midx), dut.dataMem[e.midx], e.mval);
                $display("txn pc=%08h r%0d=%08h dmem[%0d]=%08h", e.pc, e.ridx, e.rval, e.midx, e.mval);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] acc;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_pc", dbg_pc, 32'd0);
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc |= dut.mipsRegFile.registers[i];
        check("reset_regs", acc, 32'd0);

        // add $2,$2,$1 followed by NOPs
        begin_prog(); put(0, 32'h00411020); release_rst(); set_reg(1, 32'd1);
        run(1); drain();
        check("add_r2_e1", dut.mipsRegFile.registers[2], 32'd1);
        check("add_pc_e1", dbg_pc, 32'd4);
        run(4); drain();
        check("add_r2_e5", dut.mipsRegFile.registers[2], 32'd1);
        check("add_pc_e5", dbg_pc, 32'd20);

        // addi/sw/lw with negative immediate
        begin_prog(); put(0, 32'h2003FFFB); put(1, 32'hAC030008); put(2, 32'h8C040008); release_rst();
        run(3); drain();
        check("sw_dmem2", dut.dataMem[2], 32'hFFFFFFFB);
        check("lw_r4", dut.mipsRegFile.registers[4], 32'hFFFFFFFB);
        check("lw_pc", dbg_pc, 32'd12);

        // beq taken / not taken
        begin_prog(); put(0, 32'h10A60002); release_rst(); set_reg(5, 32'd7); set_reg(6, 32'd7);
        run(1); drain();
        check("beq_taken_pc", dbg_pc, 32'd12);
        begin_prog(); put(0, 32'h10A60002); release_rst(); set_reg(5, 32'd7); set_reg(6, 32'd8);
        run(1); drain();
        check("beq_not_pc", dbg_pc, 32'd4);

        // $0 guard and signed slt
        begin_prog(); put(0, 32'h20000009); put(1, 32'h0109382A); release_rst();
        set_reg(8, 32'hFFFFFFFF); set_reg(9, 32'd1);
        run(2); drain();
        check("r0_guard", dut.mipsRegFile.registers[0], 32'd0);
        check("slt_r7", dut.mipsRegFile.registers[7], 32'd1);

        // j 0x10
        begin_prog(); put(0, 32'h08000010); release_rst();
        run(1); drain();
`ifdef MIPS_JUMP_EN
        check("j_pc", dbg_pc, 32'h40);
`else
        check("j_pc", dbg_pc, 32'd4);
`endif

        // Random programs against the reference model
        for (int p = 0; p < 5; p++) begin
            begin_prog();
            for (int i = 0; i < 64; i++) put(i, rand_inst());
            release_rst();
            for (int i = 1; i < 32; i++) set_reg(i, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom);
            run(50); drain();
        end

        // Async reset mid-run; the held reset must also drop the store at word 0.
        begin_prog();
        for (int i = 1; i < 64; i++) put(i, rand_inst());
        put(0, 32'hAC010000);
        release_rst();
        for (int i = 1; i < 32; i++) set_reg(i, $urandom);
        run(10); drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", dbg_pc, 32'd0);
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc |= dut.mipsRegFile.registers[i];
        check("async_rst_regs", acc, 32'd0);
        @(posedge clk);
        #1;
        acc = 32'd0;
        for (int i = 0; i < 256; i++) if (dut.dataMem[i] !== m_dmem[i]) acc++;
        check("rst_blocks_sw", acc, 32'd0);
        check("rst_hold_pc", dbg_pc, 32'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
